// File: rtl/pdh_dac_sweep.sv
// pdh_dac_sweep: sweep sequencer and write arbiter for the PDH dual-DAC word.
// Ramps one channel between programmable limits (step/dwell), handles the PS
// four-phase command handshake and merges direct per-channel writes.
module pdh_dac_sweep #(
  parameter int unsigned DAC_W   = 14,
  parameter int unsigned DWELL_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_strobe_i,
  input  logic [3:0]           cfg_cmd_i,
  input  logic [25:0]          cfg_data_i,
  output logic                 cfg_ack_o,
  input  logic                 man_wr_i,
  input  logic                 man_sel_i,
  input  logic [DAC_W-1:0]     man_code_i,
  output logic [2*DAC_W-1:0]   dac_dat_o,
  output logic                 dac_wrt_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic                 man_rej_o
);

  localparam int unsigned DAT_W    = 2 * DAC_W;
  localparam int unsigned SUM_W    = DAC_W + 1;
  localparam int unsigned CH_BIT   = 14;
  localparam int unsigned MODE_BIT = 15;

  localparam logic [3:0] CMD_SET_START = 4'h1;
  localparam logic [3:0] CMD_SET_STOP  = 4'h2;
  localparam logic [3:0] CMD_SET_STEP  = 4'h3;
  localparam logic [3:0] CMD_SET_DWELL = 4'h4;
  localparam logic [3:0] CMD_START     = 4'h5;
  localparam logic [3:0] CMD_STOP      = 4'h6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Configuration
  logic [DAC_W-1:0]   r_start;
  logic [DAC_W-1:0]   r_stop;
  logic [DAC_W-1:0]   r_step;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_chan;
  logic               r_cont;

  // Sweep and output state
  logic               r_strb_q;
  logic [DWELL_W-1:0] r_cnt;
  logic [DAC_W-1:0]   r_cur;
  logic [DAT_W-1:0]   r_dat;
  logic               r_wrt;
  logic               r_busy;
  logic               r_err;
  logic               r_rej;

  logic               w_edge;
  logic               w_is_set;
  logic               w_set_ok;
  logic               w_start_ok;
  logic               w_stop_ok;
  logic               w_accept;
  logic               w_tick;
  logic [SUM_W-1:0]   w_up_sum;
  logic [SUM_W-1:0]   w_dn_lim;
  logic               w_up_over;
  logic               w_dn_under;
  logic [DAC_W-1:0]   w_code_in;
  logic [DWELL_W-1:0] w_dwell_in;
  logic               w_man_rej;
  logic               w_man_ok;
  logic               w_sw_wr;
  logic [DAC_W-1:0]   w_sw_code;
  logic               w_sw_chan;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic               w_fin;
  logic [DAT_W-1:0]   w_dat_nxt;
  logic               w_unused;

  assign w_unused = &{1'b0, cfg_data_i[25:16]};

  // Command decode: a command executes only in the strobe rising-edge cycle
  assign w_edge     = cfg_strobe_i & ~r_strb_q;
  assign w_code_in  = cfg_data_i[DAC_W-1:0];
  assign w_dwell_in = cfg_data_i[DWELL_W-1:0];
  assign w_is_set   = (cfg_cmd_i == CMD_SET_START) || (cfg_cmd_i == CMD_SET_STOP) ||
                      (cfg_cmd_i == CMD_SET_STEP)  || (cfg_cmd_i == CMD_SET_DWELL);
  assign w_set_ok   = w_edge && w_is_set && !r_busy;
  assign w_start_ok = w_edge && (cfg_cmd_i == CMD_START) && !r_busy && (r_start < r_stop);
  assign w_stop_ok  = w_edge && (cfg_cmd_i == CMD_STOP);
  assign w_accept   = w_set_ok || w_start_ok || w_stop_ok;

  // Step arithmetic is one bit wider so cur+step cannot wrap past stop
  assign w_tick     = (r_state != S_IDLE) && (r_cnt == '0);
  assign w_up_sum   = {1'b0, r_cur} + {1'b0, r_step};
  assign w_dn_lim   = {1'b0, r_step} + {1'b0, r_start};
  assign w_up_over  = (w_up_sum >= {1'b0, r_stop});
  assign w_dn_under = ({1'b0, r_cur} < w_dn_lim);

  // Direct writes to the channel being swept are dropped while busy
  assign w_man_rej  = man_wr_i && r_busy && (man_sel_i == r_chan);
  assign w_man_ok   = man_wr_i && !w_man_rej;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state; STOP overrides everything and suppresses the pending step
  always_comb begin
    w_state_nxt = r_state;
    if (w_stop_ok) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start_ok) w_state_nxt = S_UP;
        S_UP:    if (w_tick && w_up_over) w_state_nxt = r_cont ? S_DOWN : S_IDLE;
        S_DOWN:  if (w_tick && w_dn_under) w_state_nxt = S_UP;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs: sweep write request, code, dwell counter and merged DAC word
  always_comb begin
    w_sw_wr   = 1'b0;
    w_sw_code = r_cur;
    w_sw_chan = r_chan;
    w_cnt_nxt = r_cnt;
    w_fin     = 1'b0;
    w_dat_nxt = r_dat;
    if (w_start_ok) begin
      w_sw_wr   = 1'b1;
      w_sw_code = r_start;
      w_sw_chan = cfg_data_i[CH_BIT];
      w_cnt_nxt = r_dwell - DWELL_W'(1);
    end else if (!w_stop_ok && (r_state != S_IDLE)) begin
      if (w_tick) begin
        w_sw_wr   = 1'b1;
        w_cnt_nxt = r_dwell - DWELL_W'(1);
        if (r_state == S_UP) begin
          if (w_up_over) begin
            w_sw_code = r_stop;
            w_fin     = !r_cont;
          end else begin
            w_sw_code = w_up_sum[DAC_W-1:0];
          end
        end else begin
          w_sw_code = w_dn_under ? r_start : (r_cur - r_step);
        end
      end else begin
        w_cnt_nxt = r_cnt - DWELL_W'(1);
      end
    end
    if (w_man_ok) begin
      if (man_sel_i) w_dat_nxt[DAT_W-1:DAC_W] = man_code_i;
      else           w_dat_nxt[DAC_W-1:0]     = man_code_i;
    end
    if (w_sw_wr) begin
      if (w_sw_chan) w_dat_nxt[DAT_W-1:DAC_W] = w_sw_code;
      else           w_dat_nxt[DAC_W-1:0]     = w_sw_code;
    end
  end

  // Config, handshake, sweep datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_start  <= '0;
      r_stop   <= '1;
      r_step   <= DAC_W'(1);
      r_dwell  <= DWELL_W'(1);
      r_chan   <= 1'b0;
      r_cont   <= 1'b0;
      r_strb_q <= 1'b0;
      r_cnt    <= '0;
      r_cur    <= '0;
      r_dat    <= '0;
      r_wrt    <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_rej    <= 1'b0;
    end else begin
      r_strb_q <= cfg_strobe_i;
      if (w_set_ok) begin
        case (cfg_cmd_i)
          CMD_SET_START: r_start <= w_code_in;
          CMD_SET_STOP:  r_stop  <= w_code_in;
          CMD_SET_STEP:  r_step  <= (w_code_in == '0) ? DAC_W'(1) : w_code_in;
          CMD_SET_DWELL: r_dwell <= (w_dwell_in == '0) ? DWELL_W'(1) : w_dwell_in;
          default:       ;
        endcase
      end
      if (w_start_ok) begin
        r_chan <= cfg_data_i[CH_BIT];
        r_cont <= cfg_data_i[MODE_BIT];
      end
      if (w_accept)    r_err <= 1'b0;
      else if (w_edge) r_err <= 1'b1;
      r_cnt <= w_cnt_nxt;
      if (w_sw_wr) r_cur <= w_sw_code;
      r_dat  <= w_dat_nxt;
      r_wrt  <= w_sw_wr | w_man_ok;
      r_rej  <= w_man_rej;
      // Single-mode busy lingers one cycle past the final stop write
      r_busy <= (w_state_nxt != S_IDLE) | w_fin;
    end
  end

  // Ack follows the registered strobe: up at E+1, down one cycle after release
  assign cfg_ack_o = r_strb_q;
  assign dac_dat_o = r_dat;
  assign dac_wrt_o = r_wrt;
  assign busy_o    = r_busy;
  assign err_o     = r_err;
  assign man_rej_o = r_rej;

endmodule

// File: tb/tb_pdh_dac_sweep.sv
// Directed bench for pdh_dac_sweep with hand-computed expected values.
module tb_pdh_dac_sweep;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_strobe;
  logic [3:0]  cfg_cmd;
  logic [25:0] cfg_data;
  logic        cfg_ack;
  logic        man_wr;
  logic        man_sel;
  logic [13:0] man_code;
  logic [27:0] dac_dat;
  logic        dac_wrt;
  logic        busy;
  logic        err;
  logic        man_rej;

  int n_tests = 0;
  int n_fail  = 0;

  int seq3 [9] = '{0, 3, 6, 7, 4, 1, 0, 3, 6};

  pdh_dac_sweep #(.DAC_W(14), .DWELL_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_strobe_i (cfg_strobe),
    .cfg_cmd_i    (cfg_cmd),
    .cfg_data_i   (cfg_data),
    .cfg_ack_o    (cfg_ack),
    .man_wr_i     (man_wr),
    .man_sel_i    (man_sel),
    .man_code_i   (man_code),
    .dac_dat_o    (dac_dat),
    .dac_wrt_o    (dac_wrt),
    .busy_o       (busy),
    .err_o        (err),
    .man_rej_o    (man_rej)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobe for one cycle; returns in cycle E+1 with the strobe released
  task automatic cmd(input logic [3:0] c, input logic [25:0] d);
    cfg_cmd    = c;
    cfg_data   = d;
    cfg_strobe = 1'b1;
    step();
    cfg_strobe = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] c, input logic [25:0] d);
    cmd(c, d);
    step();
  endtask

  function automatic logic [31:0] w2(input logic [13:0] ch1, input logic [13:0] ch0);
    return {4'h0, ch1, ch0};
  endfunction

  initial begin
    rst_n      = 1'b0;
    cfg_strobe = 1'b0;
    cfg_cmd    = 4'h0;
    cfg_data   = 26'h0;
    man_wr     = 1'b0;
    man_sel    = 1'b0;
    man_code   = 14'h0;

    // Reset
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_dat",  32'(dac_dat), 32'h0);
    check("rst_wrt",  32'(dac_wrt), 32'h0);
    check("rst_busy", 32'(busy),    32'h0);
    check("rst_err",  32'(err),     32'h0);
    check("rst_ack",  32'(cfg_ack), 32'h0);
    check("rst_rej",  32'(man_rej), 32'h0);

    // Single sweep ch0 0x100..0x104 dwell 3, START strobe held for 10 cycles
    cfg(4'h1, 26'h100);
    cfg(4'h2, 26'h104);
    cfg(4'h4, 26'h3);
    cfg_cmd = 4'h5; cfg_data = 26'h0; cfg_strobe = 1'b1;
    step();
    for (int k = 1; k <= 15; k++) begin
      check("single_dat",  32'(dac_dat),
            w2(14'h0, (k <= 13) ? 14'(32'h100 + (k - 1) / 3) : 14'h104));
      check("single_wrt",  32'(dac_wrt), 32'((k <= 13) && ((k - 1) % 3 == 0)));
      check("single_busy", 32'(busy),    32'(k <= 13));
      check("single_ack",  32'(cfg_ack), 32'(k <= 10));
      check("single_err",  32'(err),     32'h0);
      if (k == 10) cfg_strobe = 1'b0;
      step();
    end

    // Continuous sweep ch1 0..7 step 3 dwell 1, then STOP
    cfg(4'h1, 26'h0);
    cfg(4'h2, 26'h7);
    cfg(4'h3, 26'h3);
    cfg(4'h4, 26'h1);
    cmd(4'h5, 26'hC000);
    for (int k = 1; k <= 8; k++) begin
      check("cont_dat", 32'(dac_dat), w2(14'(seq3[k-1]), 14'h104));
      check("cont_wrt", 32'(dac_wrt), 32'h1);
      step();
    end
    cmd(4'h6, 26'h0);
    check("stop_dat",  32'(dac_dat), w2(14'h6, 14'h104));
    check("stop_wrt",  32'(dac_wrt), 32'h0);
    check("stop_busy", 32'(busy),    32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("stop_hold_wrt", 32'(dac_wrt), 32'h0);
      check("stop_hold_dat", 32'(dac_dat), w2(14'h6, 14'h104));
    end
    step();

    // Arbitration during a ch0 sweep, dwell 4
    cfg(4'h1, 26'h200);
    cfg(4'h2, 26'h210);
    cfg(4'h3, 26'h1);
    cfg(4'h4, 26'h4);
    cmd(4'h5, 26'h0);
    check("arb_start", 32'(dac_dat), w2(14'h6, 14'h200));
    step();
    man_wr = 1'b1; man_sel = 1'b1; man_code = 14'h1ABC;
    step();
    man_wr = 1'b0;
    check("arb_ch1_dat", 32'(dac_dat), w2(14'h1ABC, 14'h200));
    check("arb_ch1_wrt", 32'(dac_wrt), 32'h1);
    check("arb_ch1_rej", 32'(man_rej), 32'h0);
    man_wr = 1'b1; man_sel = 1'b0; man_code = 14'h0555;
    step();
    man_wr = 1'b0;
    check("arb_ch0_rej", 32'(man_rej), 32'h1);
    check("arb_ch0_wrt", 32'(dac_wrt), 32'h0);
    check("arb_ch0_dat", 32'(dac_dat), w2(14'h1ABC, 14'h200));
    man_wr = 1'b1; man_sel = 1'b1; man_code = 14'h0123;
    step();
    man_wr = 1'b0;
    check("arb_merge_dat", 32'(dac_dat), w2(14'h0123, 14'h201));
    check("arb_merge_wrt", 32'(dac_wrt), 32'h1);
    check("arb_merge_rej", 32'(man_rej), 32'h0);
    step();
    check("arb_after_wrt", 32'(dac_wrt), 32'h0);
    cfg(4'h6, 26'h0);
    check("arb_stop_busy", 32'(busy), 32'h0);

    // Errors
    cfg(4'h2, 26'h200);
    cmd(4'h5, 26'h0);
    check("err_eq_err",  32'(err),     32'h1);
    check("err_eq_wrt",  32'(dac_wrt), 32'h0);
    check("err_eq_busy", 32'(busy),    32'h0);
    check("err_eq_dat",  32'(dac_dat), w2(14'h0123, 14'h201));
    step();
    cmd(4'h2, 26'h210);
    check("err_clear", 32'(err), 32'h0);
    step();
    cmd(4'h5, 26'h0);
    check("err_run_dat",  32'(dac_dat), w2(14'h0123, 14'h200));
    check("err_run_busy", 32'(busy),    32'h1);
    step();
    cmd(4'h3, 26'h5);
    check("err_busy_set", 32'(err), 32'h1);
    step();
    step();
    check("err_step_kept", 32'(dac_dat), w2(14'h0123, 14'h201));
    check("err_step_wrt",  32'(dac_wrt), 32'h1);
    cfg(4'h6, 26'h0);
    check("err_stop_busy", 32'(busy), 32'h0);
    cmd(4'hF, 26'h0);
    check("err_bad_cmd", 32'(err),     32'h1);
    check("err_bad_ack", 32'(cfg_ack), 32'h1);
    step();
    cmd(4'h4, 26'h0);
    check("err_dwell_clr", 32'(err), 32'h0);
    step();

    // Step and dwell of zero stored as one, ch1 single
    cfg(4'h3, 26'h0);
    cfg(4'h2, 26'h302);
    cfg(4'h1, 26'h300);
    cmd(4'h5, 26'h4000);
    check("zero_w0",   32'(dac_dat), w2(14'h300, 14'h201));
    check("zero_busy", 32'(busy),    32'h1);
    step();
    check("zero_w1",   32'(dac_dat), w2(14'h301, 14'h201));
    check("zero_w1_p", 32'(dac_wrt), 32'h1);
    step();
    check("zero_w2",   32'(dac_dat), w2(14'h302, 14'h201));
    check("zero_w2_b", 32'(busy),    32'h1);
    step();
    check("zero_done_busy", 32'(busy),    32'h0);
    check("zero_done_wrt",  32'(dac_wrt), 32'h0);
    step();

    // Overflow: 0x3FF0 + 0x3000 clamps to stop
    cfg(4'h2, 26'h3FFF);
    cfg(4'h1, 26'h3FF0);
    cfg(4'h3, 26'h3000);
    cmd(4'h5, 26'h0);
    check("ovf_w0", 32'(dac_dat), w2(14'h302, 14'h3FF0));
    step();
    check("ovf_w1",  32'(dac_dat), w2(14'h302, 14'h3FFF));
    check("ovf_w1p", 32'(dac_wrt), 32'h1);
    step();
    check("ovf_busy", 32'(busy),    32'h0);
    check("ovf_wrt",  32'(dac_wrt), 32'h0);
    step();

    // Reset mid-sweep, then defaults
    cfg(4'h3, 26'h1);
    cfg(4'h1, 26'h0);
    cfg(4'h2, 26'h7);
    cmd(4'h5, 26'hC000);
    step();
    step();
    rst_n = 1'b0;
    step();
    check("mrst_dat",  32'(dac_dat), 32'h0);
    check("mrst_wrt",  32'(dac_wrt), 32'h0);
    check("mrst_busy", 32'(busy),    32'h0);
    check("mrst_err",  32'(err),     32'h0);
    check("mrst_ack",  32'(cfg_ack), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    cmd(4'h5, 26'h0);
    check("dflt_w0",   32'(dac_dat), 32'h0);
    check("dflt_w0p",  32'(dac_wrt), 32'h1);
    check("dflt_busy", 32'(busy),    32'h1);
    step();
    check("dflt_w1",   32'(dac_dat), w2(14'h0, 14'h1));
    check("dflt_w1p",  32'(dac_wrt), 32'h1);
    cfg(4'h6, 26'h0);
    check("dflt_stop", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
